alu_resp: RTL and testbench

- Clocked request/response front end for the 8-bit ALU operation set: ADD, SUB, OR, AND, XOR, NOT, LSL, LSR.
- Accepts operation requests over a valid/ready handshake and computes the result in one registered stage.
- Returns result, flags and tag in request order through an output FIFO with its own valid/ready handshake.
- Sits between an instruction issuer or bench driver and result consumers.
- Self-contained datapath; does not instantiate the combinational ALU.

---
 rtl/alu_resp.sv | 138 +++++++++++++
 tb/tb_alu_resp.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_resp.sv
// alu_resp: registered 8-bit ALU stage feeding an in-order result FIFO with valid/ready on both sides
module alu_resp #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_a0,
  input  logic [7:0]       req_a1,
  input  logic             req_a_sel,
  input  logic [7:0]       req_b,
  input  logic [2:0]       req_ctrl,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      op_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = TAG_W + 11;
  localparam logic [AW+1:0] LP_DEPTH = (AW+2)'(DEPTH);

  logic [7:0]    w_a;
  logic [7:0]    w_data;
  logic          w_carry;
  logic          w_ovf;
  logic          w_big;
  logic [8:0]    w_add;
  logic [8:0]    w_sub;
  logic [8:0]    w_lsl;
  logic [8:0]    w_lsr;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_next;
  logic [AW+1:0] w_occ_next;

  logic          r_req_ready;
  logic          r_s1_valid;
  logic [EW-1:0] r_s1;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_op_count;

  // ALU result for the request currently on the inputs; shifts keep the
  // shifted-out bit in the ninth bit so carry falls out of the same vector
  always_comb begin
    w_a     = req_a_sel ? req_a1 : req_a0;
    w_add   = {1'b0, w_a} + {1'b0, req_b};
    w_sub   = {1'b0, w_a} - {1'b0, req_b};
    w_lsl   = {1'b0, w_a} << req_b[2:0];
    w_lsr   = {w_a, 1'b0} >> req_b[2:0];
    w_big   = |req_b[7:3];
    w_data  = 8'h00;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (req_ctrl)
      3'd0: begin
        w_data  = w_add[7:0];
        w_carry = w_add[8];
        w_ovf   = (w_a[7] == req_b[7]) && (w_add[7] != w_a[7]);
      end
      3'd1: begin
        w_data  = w_sub[7:0];
        w_carry = w_sub[8];
        w_ovf   = (w_a[7] != req_b[7]) && (w_sub[7] != w_a[7]);
      end
      3'd2: w_data = w_a | req_b;
      3'd3: w_data = w_a & req_b;
      3'd4: w_data = w_a ^ req_b;
      3'd5: w_data = ~w_a;
      3'd6: begin
        w_data  = w_big ? 8'h00 : w_lsl[7:0];
        w_carry = !w_big && w_lsl[8];
      end
      default: begin
        w_data  = w_big ? 8'h00 : w_lsr[8:1];
        w_carry = !w_big && w_lsr[0];
      end
    endcase
  end

  assign w_accept     = req_valid & r_req_ready;
  assign w_push       = r_s1_valid;
  assign w_pop        = rsp_valid & rsp_ready;
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_occ_next   = (AW+2)'(w_count_next) + (AW+2)'(w_accept);

  assign req_ready = r_req_ready;
  assign rsp_valid = r_count != '0;
  assign {rsp_tag, rsp_ovf, rsp_zero, rsp_carry, rsp_data} = r_mem[r_rd_ptr];
  assign op_count  = r_op_count;

  // Result stage: capture the accepted request's result, tag and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1 <= {req_tag, w_ovf, w_data == 8'h00, w_carry, w_data};
    end
  end

  // Result FIFO; ready counts the stage entry as occupied so an accept
  // always finds a free slot on the following push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_s1;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_next;
      r_req_ready <= w_occ_next < LP_DEPTH;
    end
  end

  // Accepted-request counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_op_count <= 16'h0000;
    else if (w_accept) r_op_count <= r_op_count + 16'h0001;
  end
endmodule

// File: tb/tb_alu_resp.sv
// tb_alu_resp: directed and randomized checks of alu_resp against a queue-based arithmetic model
module tb_alu_resp;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_a0 = 8'h00;
  logic [7:0] req_a1 = 8'h00;
  logic       req_a_sel = 1'b0;
  logic [7:0] req_b = 8'h00;
  logic [2:0] req_ctrl = 3'd0;
  logic [3:0] req_tag = 4'h0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_ovf;
  logic [3:0] rsp_tag;
  logic [15:0] op_count;

  int n_chk = 0;
  int n_fail = 0;
  int model_ops = 0;
  logic [14:0] exp_q[$];

  alu_resp #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_a_sel(req_a_sel), .req_b(req_b),
    .req_ctrl(req_ctrl), .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
    .rsp_tag(rsp_tag), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // returns {ovf, zero, carry, data} from plain integer arithmetic
  function automatic logic [10:0] ref_alu(input logic [2:0] op, input int a, input int b);
    int d, c, v, sa, sb;
    d = 0; c = 0; v = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      3'd0: begin d = a + b; c = (d > 255); v = (sa + sb > 127) || (sa + sb < -128); d = d % 256; end
      3'd1: begin c = (a < b); d = (a - b + 256) % 256; v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: d = a | b;
      3'd3: d = a & b;
      3'd4: d = a ^ b;
      3'd5: d = 255 - a;
      3'd6: if (b < 8) begin d = (a << b) % 256; c = (b > 0) ? ((a << b) >> 8) & 1 : 0; end
      default: if (b < 8) begin d = a >> b; c = (b > 0) ? (a >> (b - 1)) & 1 : 0; end
    endcase
    return {v != 0, d == 0, c != 0, 8'(d)};
  endfunction

  // model: record accepts and compare pops at the falling edge before the edge that performs them
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_ops = 0;
    end else begin
      if (req_valid && req_ready) begin
        exp_q.push_back({req_tag, ref_alu(req_ctrl, int'(req_a_sel ? req_a1 : req_a0), int'(req_b))});
        model_ops++;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_tag), 32'hFFFF_FFFF);
        else chk("rsp_order", 32'({rsp_tag, rsp_ovf, rsp_zero, rsp_carry, rsp_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input logic [3:0] tag);
    req_ctrl  = 3'($urandom);
    req_a_sel = 1'($urandom);
    req_a0    = 8'($urandom);
    req_a1    = 8'($urandom);
    req_b     = ($urandom % 4 == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
    req_tag   = tag;
  endtask

  task automatic send(input logic [2:0] op, input logic sel, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    int k;
    req_ctrl  = op;
    req_a_sel = sel;
    req_a0    = sel ? 8'($urandom) : a;
    req_a1    = sel ? a : 8'($urandom);
    req_b     = b;
    req_tag   = tag;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    if (!req_ready) chk("send_timeout", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic one(input string name, input logic [2:0] op, input logic sel, input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] tag, input logic [7:0] ed, input logic ec, input logic ez, input logic ev);
    int k;
    rsp_ready = 1'b0;
    send(op, sel, a, b, tag);
    k = 0;
    while (!rsp_valid && k < 10) begin
      tick();
      k++;
    end
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk(name, 32'({rsp_tag, rsp_ovf, rsp_zero, rsp_carry, rsp_data}), 32'({tag, ev, ez, ec, ed}));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n_acc, n_pop, cyc;
    logic [15:0] base;
    logic a, p;
    repeat (2) tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_head", 32'({rsp_tag, rsp_ovf, rsp_zero, rsp_carry, rsp_data}), 32'd0);
    chk("rst_opcnt", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", 32'(req_ready), 32'd0);
    tick();
    chk("ready_rise", 32'(req_ready), 32'd1);

    req_ctrl = 3'd0; req_a_sel = 1'b1; req_a1 = 8'h10; req_a0 = 8'hEE; req_b = 8'h10; req_tag = 4'h1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("lat_s1", 32'(rsp_valid), 32'd0);
    chk("opcnt_1", 32'(op_count), 32'd1);
    tick();
    chk("lat_fifo", 32'(rsp_valid), 32'd1);
    chk("add_first", 32'({rsp_tag, rsp_ovf, rsp_zero, rsp_carry, rsp_data}), 32'({4'h1, 1'b0, 1'b0, 1'b0, 8'h20}));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("drained", 32'(rsp_valid), 32'd0);

    one("sub_a", 3'd1, 1'b1, 8'h41, 8'h03, 4'h2, 8'h3E, 1'b0, 1'b0, 1'b0);
    one("sub_b", 3'd1, 1'b1, 8'h03, 8'h41, 4'h3, 8'hC2, 1'b1, 1'b0, 1'b0);
    one("sub_ovf", 3'd1, 1'b0, 8'h80, 8'h01, 4'h4, 8'h7F, 1'b0, 1'b0, 1'b1);
    one("add_zero", 3'd0, 1'b0, 8'h50, 8'hB0, 4'h5, 8'h00, 1'b1, 1'b1, 1'b0);
    one("lsl_a", 3'd6, 1'b0, 8'h09, 8'h01, 4'h6, 8'h12, 1'b0, 1'b0, 1'b0);
    one("lsl_b", 3'd6, 1'b1, 8'h81, 8'h01, 4'h7, 8'h02, 1'b1, 1'b0, 1'b0);
    one("lsr_a", 3'd7, 1'b0, 8'h06, 8'h02, 4'h8, 8'h01, 1'b1, 1'b0, 1'b0);
    one("lsr_big", 3'd7, 1'b1, 8'hFF, 8'h22, 4'h9, 8'h00, 1'b0, 1'b1, 1'b0);
    one("not", 3'd5, 1'b0, 8'h88, 8'h5A, 4'hA, 8'h77, 1'b0, 1'b0, 1'b0);
    one("lsl_zero_n", 3'd6, 1'b0, 8'hA5, 8'h00, 4'hB, 8'hA5, 1'b0, 1'b0, 1'b0);
    one("lsl_8", 3'd6, 1'b0, 8'hFF, 8'h08, 4'hC, 8'h00, 1'b0, 1'b1, 1'b0);

    // backpressure: six tagged requests offered, only four fit
    base = op_count;
    rsp_ready = 1'b0;
    n_acc = 0;
    rand_req(4'h0);
    req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a = req_ready;
      tick();
      if (a) begin
        n_acc++;
        if (n_acc < 6) rand_req(4'(n_acc));
        else req_valid = 1'b0;
      end
    end
    chk("bp_accepts", 32'(n_acc), 32'd4);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    chk("bp_opcnt", 32'(op_count), 32'(base + 16'd4));
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_tag", 32'(rsp_tag), 32'(k));
      rsp_ready = 1'b1;
      tick();
      if (k == 0) chk("bp_ready_back", 32'(req_ready), 32'd1);
    end
    rsp_ready = 1'b0;
    chk("bp_empty", 32'(rsp_valid), 32'd0);

    // streaming: one accept and one response per cycle
    rsp_ready = 1'b1;
    n_acc = 0;
    n_pop = 0;
    rand_req(4'h0);
    req_valid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      a = req_valid && req_ready;
      p = rsp_valid && rsp_ready;
      tick();
      if (a) begin
        n_acc++;
        if (n_acc < 20) rand_req(4'(n_acc));
        else req_valid = 1'b0;
      end
      if (p) n_pop++;
    end
    chk("stream_acc", 32'(n_acc), 32'd20);
    chk("stream_pop", 32'(n_pop), 32'd20);
    rsp_ready = 1'b0;

    // reset with three entries queued and one in the result stage
    n_acc = 0;
    cyc = 0;
    rand_req(4'h0);
    req_valid = 1'b1;
    while (n_acc < 4 && cyc < 20) begin
      a = req_ready;
      tick();
      cyc++;
      if (a) begin
        n_acc++;
        rand_req(4'(n_acc));
      end
    end
    req_valid = 1'b0;
    chk("rstmid_pre", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_opcnt", 32'(op_count), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    one("rstmid_first", 3'd0, 1'b0, 8'h01, 8'h01, 4'hD, 8'h02, 1'b0, 1'b0, 1'b0);

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rand_req(4'($urandom));
      req_valid = ($urandom % 4) != 0;
      rsp_ready = ($urandom % 3) != 0;
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) tick();
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    chk("rand_opcnt", 32'(op_count), 32'(16'(model_ops)));

    // op_count wrap after 65535 accepts
    rst_n = 1'b0;
    req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rsp_ready = 1'b1;
    n_acc = 0;
    cyc = 0;
    rand_req(4'h0);
    req_valid = 1'b1;
    while (n_acc < 65535 && cyc < 70000) begin
      a = req_ready;
      tick();
      cyc++;
      if (a) n_acc++;
      rand_req(4'(n_acc));
    end
    req_valid = 1'b0;
    chk("wrap_pre", 32'(op_count), 32'h0000_FFFF);
    send(3'd4, 1'b0, 8'h3C, 8'hC3, 4'hE);
    chk("wrap", 32'(op_count), 32'd0);
    repeat (6) tick();
    chk("wrap_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
